// File: rtl/wb_stage.sv
// Registered write-back stage: source select, load alignment, memory wait with timeout.
// Optional load alignment/extension is enabled by defining WB_LOAD_ALIGN_EN.
module wb_stage #(
    parameter int unsigned XLEN        = 32,
    parameter int unsigned NSRC        = 4,
    parameter int unsigned MEMSRC      = 1,
    parameter int unsigned SELW        = $clog2(NSRC),
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                 Clk,
    input  logic                 RstN,
    input  logic                 InValid,
    output logic                 InReady,
    input  logic [SELW-1:0]      RUDataWrSrc,
    input  logic [NSRC*XLEN-1:0] SrcBus,
    input  logic [XLEN-1:0]      DataRd,
    input  logic                 DataRdValid,
    input  logic [4:0]           RdAddrIn,
    input  logic                 RegWrite,
    input  logic [2:0]           Funct3,
    input  logic [1:0]           AddrLow,
    output logic [XLEN-1:0]      RUDataWr,
    output logic [4:0]           RUAddrWr,
    output logic                 RUWr,
    output logic                 MemErr
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_MEM,
        WRITE
    } state_t;

    state_t          state, state_n;
    logic [7:0]      cnt, cnt_n;
    logic [XLEN-1:0] data_n;
    logic [4:0]      addr_n;
    logic            regwr_q, regwr_n;
    logic            memerr_n;
    logic            accept;
    logic            is_mem;
    logic [XLEN-1:0] src_data;
    logic [XLEN-1:0] load_word;

    // Out-of-range selectors fall through the loop and leave the result at zero.
    always_comb begin
        src_data = '0;
        for (int unsigned k = 0; k < NSRC; k++) begin
            if (SELW'(k) == RUDataWrSrc) begin
                src_data = SrcBus[k*XLEN +: XLEN];
            end
        end
    end

`ifdef WB_LOAD_ALIGN_EN
    logic [2:0] f3_q;
    logic [1:0] al_q;
    logic [2:0] ld_f3;
    logic [1:0] ld_al;

    function automatic logic [XLEN-1:0] align_load(input logic [XLEN-1:0] d,
                                                   input logic [2:0] f3,
                                                   input logic [1:0] al);
        logic [7:0]  b;
        logic [15:0] h;
        b = d[8*al +: 8];
        h = al[1] ? d[31:16] : d[15:0];
        case (f3)
            3'b000:  align_load = XLEN'($signed(b));
            3'b001:  align_load = XLEN'($signed(h));
            3'b010:  align_load = XLEN'($signed(d[31:0]));
            3'b100:  align_load = XLEN'(b);
            3'b101:  align_load = XLEN'(h);
            default: align_load = d;
        endcase
    endfunction

    // A waiting load aligns with the attributes captured at accept time.
    always_comb begin
        ld_f3     = (state == WAIT_MEM) ? f3_q : Funct3;
        ld_al     = (state == WAIT_MEM) ? al_q : AddrLow;
        load_word = align_load(DataRd, ld_f3, ld_al);
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            f3_q <= '0;
            al_q <= '0;
        end else if (accept) begin
            f3_q <= Funct3;
            al_q <= AddrLow;
        end
    end
`else
    logic unused_ld;
    assign unused_ld = ^{Funct3, AddrLow};
    assign load_word = DataRd;
`endif

    assign InReady = (state != WAIT_MEM);
    assign accept  = InValid && InReady;
    assign is_mem  = (RUDataWrSrc == SELW'(MEMSRC));
    assign RUWr    = (state == WRITE) && regwr_q && (RUAddrWr != 5'd0);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        data_n   = RUDataWr;
        addr_n   = RUAddrWr;
        regwr_n  = regwr_q;
        memerr_n = 1'b0;
        case (state)
            WAIT_MEM: begin
                if (DataRdValid) begin
                    data_n  = load_word;
                    state_n = WRITE;
                end else if (cnt == 8'(MEM_TIMEOUT - 1)) begin
                    memerr_n = 1'b1;
                    cnt_n    = '0;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + 8'd1;
                end
            end
            default: begin
                if (accept) begin
                    addr_n  = RdAddrIn;
                    regwr_n = RegWrite;
                    if (!is_mem) begin
                        data_n  = src_data;
                        state_n = WRITE;
                    end else if (DataRdValid) begin
                        data_n  = load_word;
                        state_n = WRITE;
                    end else begin
                        cnt_n   = '0;
                        state_n = WAIT_MEM;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge Clk or negedge RstN) begin
        if (!RstN) begin
            state    <= IDLE;
            cnt      <= '0;
            RUDataWr <= '0;
            RUAddrWr <= '0;
            regwr_q  <= 1'b0;
            MemErr   <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            RUDataWr <= data_n;
            RUAddrWr <= addr_n;
            regwr_q  <= regwr_n;
            MemErr   <= memerr_n;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// Randomized self-checking bench for wb_stage against a transaction-level reference model.
module tb_wb_stage;

    localparam int unsigned XLEN = 32;
    localparam int unsigned NSRC = 5;
    localparam int unsigned MEMSRC = 1;
    localparam int unsigned SELW = 3;
    localparam int unsigned TMO = 15;

    logic                 Clk;
    logic                 RstN;
    logic                 inv;
    logic                 InReady;
    logic [SELW-1:0]      sel;
    logic [NSRC*XLEN-1:0] bus;
    logic [XLEN-1:0]      drd;
    logic                 drv;
    logic [4:0]           rd;
    logic                 rw;
    logic [2:0]           f3;
    logic [1:0]           al;
    logic [XLEN-1:0]      RUDataWr;
    logic [4:0]           RUAddrWr;
    logic                 RUWr;
    logic                 MemErr;

    wb_stage #(
        .XLEN(XLEN),
        .NSRC(NSRC),
        .MEMSRC(MEMSRC),
        .SELW(SELW),
        .MEM_TIMEOUT(TMO)
    ) dut (
        .Clk(Clk),
        .RstN(RstN),
        .InValid(inv),
        .InReady(InReady),
        .RUDataWrSrc(sel),
        .SrcBus(bus),
        .DataRd(drd),
        .DataRdValid(drv),
        .RdAddrIn(rd),
        .RegWrite(rw),
        .Funct3(f3),
        .AddrLow(al),
        .RUDataWr(RUDataWr),
        .RUAddrWr(RUAddrWr),
        .RUWr(RUWr),
        .MemErr(MemErr)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    int total = 0;
    int bad = 0;

    // Reference model: the pending load and the visible register contents.
    logic [31:0] m_data;
    logic [4:0]  m_addr;
    logic        e_wr, e_err;
    int          pend, waited;
    logic [2:0]  p_f3;
    logic [1:0]  p_al;
    logic        p_rw;
    logic [4:0]  p_rd;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] d, input logic [2:0] t,
                                             input logic [1:0] a);
`ifdef WB_LOAD_ALIGN_EN
        logic [31:0] sb, sh;
        sb = (d >> (8 * a)) & 32'hFF;
        sh = (d >> (16 * a[1])) & 32'hFFFF;
        case (t)
            3'd0: return (sb >= 32'h80) ? sb - 32'h100 : sb;
            3'd1: return (sh >= 32'h8000) ? sh - 32'h10000 : sh;
            3'd4: return sb;
            3'd5: return sh;
            default: return d;
        endcase
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        m_data = '0;
        m_addr = '0;
        e_wr   = 1'b0;
        e_err  = 1'b0;
        pend   = 0;
        waited = 0;
    endtask

    // Applies the rules to the inputs seen at the coming edge.
    task automatic model_edge();
        e_wr  = 1'b0;
        e_err = 1'b0;
        if (pend != 0) begin
            if (drv) begin
                m_data = ref_load(drd, p_f3, p_al);
                pend   = 0;
                e_wr   = p_rw && (p_rd != 0);
            end else begin
                waited++;
                if (waited == TMO) begin
                    pend  = 0;
                    e_err = 1'b1;
                end
            end
        end else if (inv) begin
            m_addr = rd;
            if (sel == MEMSRC) begin
                if (drv) begin
                    m_data = ref_load(drd, f3, al);
                    e_wr   = rw && (rd != 0);
                end else begin
                    pend   = 1;
                    waited = 0;
                    p_f3 = f3; p_al = al; p_rw = rw; p_rd = rd;
                end
            end else begin
                m_data = (sel < NSRC) ? bus[sel*32 +: 32] : 32'h0;
                e_wr   = rw && (rd != 0);
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge Clk);
        #1;
        check("ruwr", 32'(RUWr), 32'(e_wr));
        check("memerr", 32'(MemErr), 32'(e_err));
        check("inready", 32'(InReady), 32'(pend == 0));
        check("rudatawr", RUDataWr, m_data);
        check("ruaddrwr", 32'(RUAddrWr), 32'(m_addr));
    endtask

    task automatic idle_inputs();
        inv = 0; sel = 0; drv = 0; drd = 0; rd = 0; rw = 0; f3 = 0; al = 0; bus = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ruwr"}, 32'(RUWr), 32'd0);
        check({tag, "_memerr"}, 32'(MemErr), 32'd0);
        check({tag, "_data"}, RUDataWr, 32'd0);
        check({tag, "_addr"}, 32'(RUAddrWr), 32'd0);
        check({tag, "_ready"}, 32'(InReady), 32'd1);
    endtask

    initial begin
        idle_inputs();
        RstN = 1'b0;
        model_reset();
        #1;
        check_zero("reset");
        repeat (2) @(posedge Clk);
        @(negedge Clk);
        RstN = 1'b1;

        // ALU result then back-to-back next-address source
        inv = 1; sel = 0; bus[0 +: 32] = 32'h0000_1234; rd = 5; rw = 1;
        step();
        check("tp_alu_data", RUDataWr, 32'h0000_1234);
        check("tp_alu_addr", 32'(RUAddrWr), 32'd5);
        check("tp_alu_wr", 32'(RUWr), 32'd1);
        sel = 2; bus[64 +: 32] = 32'h0000_0008; rd = 6;
        step();
        check("tp_b2b_wr", 32'(RUWr), 32'd1);
        check("tp_b2b_data", RUDataWr, 32'h0000_0008);
        inv = 0;
        step();

        // LB load with data arriving on the third wait cycle
        inv = 1; sel = 3'(MEMSRC); f3 = 3'b000; al = 0; rd = 9; rw = 1;
        step();
        inv = 0;
        check("tp_lb_ready0", 32'(InReady), 32'd0);
        step();
        step();
        check("tp_lb_ready2", 32'(InReady), 32'd0);
        drv = 1; drd = 32'h8070_60F0;
        step();
`ifdef WB_LOAD_ALIGN_EN
        check("tp_lb_data", RUDataWr, 32'hFFFF_FFF0);
`else
        check("tp_lb_data", RUDataWr, 32'h8070_60F0);
`endif
        check("tp_lb_wr", 32'(RUWr), 32'd1);
        drv = 0;
        step();

        // LHU upper half with same-cycle data
        inv = 1; sel = 3'(MEMSRC); f3 = 3'b101; al = 2; rd = 10; drv = 1; drd = 32'h8070_60F0;
        step();
`ifdef WB_LOAD_ALIGN_EN
        check("tp_lhu_data", RUDataWr, 32'h0000_8070);
`else
        check("tp_lhu_data", RUDataWr, 32'h8070_60F0);
`endif
        drv = 0;

        // rd=0 suppresses the strobe; selector beyond NSRC yields zero
        sel = 0; bus[0 +: 32] = 32'hDEAD_BEEF; rd = 0; rw = 1;
        step();
        check("tp_rd0_wr", 32'(RUWr), 32'd0);
        sel = 7; rd = 4;
        step();
        check("tp_sel7_data", RUDataWr, 32'd0);
        check("tp_sel7_wr", 32'(RUWr), 32'd1);

        // Load timeout
        sel = 3'(MEMSRC); rd = 11; drv = 0;
        step();
        inv = 0;
        for (int i = 0; i < int'(TMO); i++) step();
        check("tp_tmo_err", 32'(MemErr), 32'd1);
        check("tp_tmo_ready", 32'(InReady), 32'd1);
        step();
        check("tp_tmo_err_off", 32'(MemErr), 32'd0);

        // Asynchronous reset in the middle of a wait
        inv = 1; sel = 3'(MEMSRC); rd = 12; rw = 1;
        step();
        inv = 0;
        step();
        step();
        #2;
        RstN = 1'b0;
        #1;
        model_reset();
        check_zero("midrst");
        @(negedge Clk);
        RstN = 1'b1;
        drv = 1; drd = 32'h1111_2222;
        step();
        check("midrst_nowr", 32'(RUWr), 32'd0);
        drv = 0;
        step();

        // Randomized traffic, alternating plentiful and scarce memory responses
        for (int i = 0; i < 3000; i++) begin
            inv = ($urandom_range(0, 3) != 0);
            sel = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 2) == 0) sel = 3'(MEMSRC);
            for (int k = 0; k < int'(NSRC); k++) bus[k*32 +: 32] = $urandom;
            drd = $urandom;
            if (((i / 300) % 2) == 1) drv = ($urandom_range(0, 19) == 0);
            else drv = ($urandom_range(0, 2) == 0);
            rd = 5'($urandom_range(0, 31));
            rw = ($urandom_range(0, 5) != 0);
            f3 = 3'($urandom_range(0, 7));
            al = 2'($urandom_range(0, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
